// File: rtl/mem_responder_pkg.sv
// Shared register map for the memory responder: offsets, bit positions, reset values.
// Latency: n/a (constants only).
// Backpressure: n/a; CPU test programs can import the same values.
package mem_responder_pkg;

  // Byte offsets inside the 32-byte peripheral window
  localparam logic [4:0] OFF_MTIME    = 5'h00;
  localparam logic [4:0] OFF_MTIMECMP = 5'h04;
  localparam logic [4:0] OFF_CTRL     = 5'h08;
  localparam logic [4:0] OFF_STATUS   = 5'h0C;
  localparam logic [4:0] OFF_GPIO     = 5'h10;

  // Word index of each register (address bits [4:2])
  localparam logic [2:0] REG_MTIME    = OFF_MTIME[4:2];
  localparam logic [2:0] REG_MTIMECMP = OFF_MTIMECMP[4:2];
  localparam logic [2:0] REG_CTRL     = OFF_CTRL[4:2];
  localparam logic [2:0] REG_STATUS   = OFF_STATUS[4:2];
  localparam logic [2:0] REG_GPIO     = OFF_GPIO[4:2];

  // CTRL bit positions
  localparam int CTRL_COUNT_EN = 0;
  localparam int CTRL_IRQ_EN   = 1;

  // STATUS bit positions
  localparam int STATUS_PENDING = 0;
  localparam int STATUS_BUS_ERR = 1;

  // Compare register starts far away so no interrupt fires out of reset
  localparam logic [31:0] MTIMECMP_RESET = 32'hFFFF_FFFF;

endpackage

// File: rtl/mem_responder_if.sv
// CPU data-bus bundle: write strobe, shared read/write address, write data, read data.
// Latency: read data is combinational on the address.
// Backpressure: none; the responder accepts every access in the cycle it is presented.
interface mem_responder_if;
  logic        MemWrite;
  logic [31:0] Mem_WrAddr;
  logic [31:0] Mem_WrData;
  logic [31:0] ReadData;

  modport master (output MemWrite, output Mem_WrAddr, output Mem_WrData, input ReadData);
  modport slave  (input MemWrite, input Mem_WrAddr, input Mem_WrData, output ReadData);
endinterface

// File: rtl/mem_responder_mmio_timer.sv
// Free-running timer with compare, control and a sticky pending flag.
// Latency: register writes and the compare result land on the next rising edge.
// Backpressure: none; writes are always accepted.
module mmio_timer
  import mem_responder_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        mtime_we,
  input  logic        mtimecmp_we,
  input  logic        ctrl_we,
  input  logic        status_we,
  input  logic [31:0] wdata,
  output logic [31:0] mtime,
  output logic [31:0] mtimecmp,
  output logic [1:0]  ctrl,
  output logic        pending,
  output logic        irq
);

  logic match;
  logic pending_clr;

  assign match       = (mtime == mtimecmp);
  assign pending_clr = status_we & wdata[STATUS_PENDING];

  // Timer state: a write to MTIME beats the increment; a compare hit beats a W1C clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mtime    <= '0;
      mtimecmp <= MTIMECMP_RESET;
      ctrl     <= '0;
      pending  <= 1'b0;
    end else begin
      if (mtime_we)
        mtime <= wdata;
      else if (ctrl[CTRL_COUNT_EN])
        mtime <= mtime + 32'd1;
      if (mtimecmp_we)
        mtimecmp <= wdata;
      if (ctrl_we)
        ctrl <= wdata[1:0];
      pending <= match | (pending & ~pending_clr);
    end
  end

  // Both operands are flops, so the interrupt has no path from the bus inputs
  assign irq = pending & ctrl[CTRL_IRQ_EN];

endmodule

// File: rtl/mem_responder.sv
// Single-cycle CPU data memory: word RAM at 0, timer/GPIO/status window at MMIO_BASE.
// Latency: reads combinational, writes commit on the rising edge.
// Backpressure: none; unmapped writes are dropped and flagged in STATUS.bus_err.
module mem_responder #(
  parameter int          RAM_WORDS = 256,
  parameter logic [31:0] MMIO_BASE = 32'h0200_0000
) (
  input  logic            clk,
  input  logic            reset,
  mem_responder_if.slave  bus,
  output logic [7:0]      gpio_out,
  output logic            timer_irq
);
  import mem_responder_pkg::*;

  localparam int          AW        = $clog2(4 * RAM_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(4 * RAM_WORDS);

  logic [31:0] ram [RAM_WORDS];

  logic          ram_hit;
  logic          mmio_hit;
  logic [2:0]    reg_sel;
  logic [AW-3:0] ram_idx;
  logic          ram_we;
  logic          reg_we;
  logic          status_we;
  logic          bus_err;
  logic [7:0]    gpio;
  logic [31:0]   rdata;

  logic [31:0]   mtime;
  logic [31:0]   mtimecmp;
  logic [1:0]    ctrl;
  logic          pending;

  // Byte lane bits are irrelevant for word-only access
  logic          unused_lane_bits;
  assign unused_lane_bits = ^bus.Mem_WrAddr[1:0];

  // Address decode; RAM takes priority should the regions ever overlap
  assign ram_hit   = (bus.Mem_WrAddr < RAM_BYTES);
  assign mmio_hit  = ~ram_hit & (bus.Mem_WrAddr[31:5] == MMIO_BASE[31:5]);
  assign reg_sel   = bus.Mem_WrAddr[4:2];
  assign ram_idx   = bus.Mem_WrAddr[AW-1:2];
  assign ram_we    = bus.MemWrite & ram_hit & ~reset;
  assign reg_we    = bus.MemWrite & mmio_hit;
  assign status_we = reg_we & (reg_sel == REG_STATUS);

  mmio_timer u_timer (
    .clk         (clk),
    .reset       (reset),
    .mtime_we    (reg_we & (reg_sel == REG_MTIME)),
    .mtimecmp_we (reg_we & (reg_sel == REG_MTIMECMP)),
    .ctrl_we     (reg_we & (reg_sel == REG_CTRL)),
    .status_we   (status_we),
    .wdata       (bus.Mem_WrData),
    .mtime       (mtime),
    .mtimecmp    (mtimecmp),
    .ctrl        (ctrl),
    .pending     (pending),
    .irq         (timer_irq)
  );

  // RAM storage is deliberately left unreset
  always_ff @(posedge clk) begin
    if (ram_we)
      ram[ram_idx] <= bus.Mem_WrData;
  end

  // GPIO register and sticky bus error; a new unmapped write wins over a W1C clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gpio    <= '0;
      bus_err <= 1'b0;
    end else begin
      if (reg_we && (reg_sel == REG_GPIO))
        gpio <= bus.Mem_WrData[7:0];
      bus_err <= (bus.MemWrite & ~ram_hit & ~mmio_hit)
               | (bus_err & ~(status_we & bus.Mem_WrData[STATUS_BUS_ERR]));
    end
  end

  // Zero-latency read mux; unmapped space and unused register bits read as zero
  always_comb begin
    rdata = '0;
    if (ram_hit) begin
      rdata = ram[ram_idx];
    end else if (mmio_hit) begin
      case (reg_sel)
        REG_MTIME:    rdata = mtime;
        REG_MTIMECMP: rdata = mtimecmp;
        REG_CTRL:     rdata = {30'b0, ctrl};
        REG_STATUS:   rdata = {30'b0, bus_err, pending};
        REG_GPIO:     rdata = {24'b0, gpio};
        default:      rdata = '0;
      endcase
    end
  end

  assign bus.ReadData = rdata;
  assign gpio_out     = gpio;

endmodule

// File: tb/tb_mem_responder.sv
// Directed plus randomized bench for mem_responder against an address-map level reference model.
// Latency: outputs sampled 1 time unit after each rising edge; reads sampled 1 unit after the address changes.
// Backpressure: none to model; every access completes in its own cycle.
module tb_mem_responder;
  import mem_responder_pkg::*;

  localparam int          RAM_WORDS = 256;
  localparam logic [31:0] MMIO_BASE = 32'h0200_0000;
  localparam logic [31:0] RAM_BYTES = 32'(4 * RAM_WORDS);

  logic       clk;
  logic       reset;
  logic [7:0] gpio_out;
  logic       timer_irq;

  mem_responder_if bus ();

  mem_responder #(.RAM_WORDS(RAM_WORDS), .MMIO_BASE(MMIO_BASE)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .gpio_out  (gpio_out),
    .timer_irq (timer_irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: architectural register values and a sparse RAM image
  logic [31:0] m_ram [int];
  int          m_keys [$];
  logic [31:0] m_mtime, m_cmp, m_ctrl, m_gpio;
  bit          m_pend, m_berr;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mtime = 32'h0;
    m_cmp   = 32'hFFFF_FFFF;
    m_ctrl  = 32'h0;
    m_gpio  = 32'h0;
    m_pend  = 1'b0;
    m_berr  = 1'b0;
  endtask

  function automatic bit is_mmio(logic [31:0] a);
    return (a >= MMIO_BASE) && (a < MMIO_BASE + 32'd32) && (a >= RAM_BYTES);
  endfunction

  // One clock edge worth of architectural effect, computed from the old values
  task automatic model_clock(bit we, logic [31:0] a, logic [31:0] d);
    logic [31:0] n_mtime, n_cmp, n_ctrl, n_gpio;
    bit          n_pend, n_berr;
    int          off;
    n_mtime = m_ctrl[0] ? m_mtime + 32'd1 : m_mtime;
    n_cmp   = m_cmp;
    n_ctrl  = m_ctrl;
    n_gpio  = m_gpio;
    n_pend  = m_pend;
    n_berr  = m_berr;
    if (we) begin
      if (a < RAM_BYTES) begin
        if (!m_ram.exists(int'(a / 4))) m_keys.push_back(int'(a / 4));
        m_ram[int'(a / 4)] = d;
      end else if (is_mmio(a)) begin
        off = int'(a - MMIO_BASE) / 4 * 4;
        if (off == 0)  n_mtime = d;
        if (off == 4)  n_cmp   = d;
        if (off == 8)  n_ctrl  = d & 32'h3;
        if (off == 12) begin
          if (d[0]) n_pend = 1'b0;
          if (d[1]) n_berr = 1'b0;
        end
        if (off == 16) n_gpio = d & 32'hFF;
      end else begin
        n_berr = 1'b1;
      end
    end
    if (m_mtime == m_cmp) n_pend = 1'b1;
    m_mtime = n_mtime; m_cmp = n_cmp; m_ctrl = n_ctrl; m_gpio = n_gpio;
    m_pend = n_pend; m_berr = n_berr;
  endtask

  function automatic logic [31:0] model_read(logic [31:0] a);
    int off;
    if (a < RAM_BYTES) return m_ram.exists(int'(a / 4)) ? m_ram[int'(a / 4)] : 32'hx;
    if (!is_mmio(a)) return 32'h0;
    off = int'(a - MMIO_BASE) / 4 * 4;
    case (off)
      0:       return m_mtime;
      4:       return m_cmp;
      8:       return m_ctrl;
      12:      return {30'h0, m_berr, m_pend};
      16:      return m_gpio;
      default: return 32'h0;
    endcase
  endfunction

  task automatic do_cycle(bit we, logic [31:0] a, logic [31:0] d);
    bus.MemWrite   = we;
    bus.Mem_WrAddr = a;
    bus.Mem_WrData = d;
    @(posedge clk);
    #1;
    model_clock(we, a, d);
    bus.MemWrite = 1'b0;
    chk("gpio_out", {24'h0, gpio_out}, m_gpio);
    chk("timer_irq", {31'h0, timer_irq}, {31'h0, m_pend & m_ctrl[1]});
  endtask

  task automatic check_read(string tag, logic [31:0] a);
    bus.MemWrite   = 1'b0;
    bus.Mem_WrAddr = a;
    #1;
    chk(tag, bus.ReadData, model_read(a));
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) do_cycle(1'b0, 32'h0, 32'h0);
  endtask

  localparam logic [31:0] A_MTIME  = MMIO_BASE + 32'(OFF_MTIME);
  localparam logic [31:0] A_CMP    = MMIO_BASE + 32'(OFF_MTIMECMP);
  localparam logic [31:0] A_CTRL   = MMIO_BASE + 32'(OFF_CTRL);
  localparam logic [31:0] A_STATUS = MMIO_BASE + 32'(OFF_STATUS);
  localparam logic [31:0] A_GPIO   = MMIO_BASE + 32'(OFF_GPIO);

  initial begin
    logic [31:0] a, d;
    int          op;

    // Reset state
    reset = 1'b1;
    bus.MemWrite = 1'b0; bus.Mem_WrAddr = 32'h0; bus.Mem_WrData = 32'h0;
    model_reset();
    #1;
    chk("rst_gpio_out", {24'h0, gpio_out}, 32'h0);
    chk("rst_timer_irq", {31'h0, timer_irq}, 32'h0);
    @(posedge clk); #1;
    check_read("rst_mtime", A_MTIME);
    check_read("rst_mtimecmp", A_CMP);
    check_read("rst_ctrl", A_CTRL);
    check_read("rst_status", A_STATUS);
    @(posedge clk); #1;
    reset = 1'b0;
    idle(1);

    // RAM write then read with and without low address bits
    do_cycle(1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    check_read("ram_0x10", 32'h0000_0010);
    check_read("ram_0x13", 32'h0000_0013);
    chk("ram_0x13_const", bus.ReadData, 32'hDEAD_BEEF);

    // GPIO
    do_cycle(1'b1, A_GPIO, 32'h0000_0055);
    chk("gpio_0x55", {24'h0, gpio_out}, 32'h55);
    check_read("gpio_read", A_GPIO);

    // Compare / interrupt sequence
    do_cycle(1'b1, A_CMP, 32'd5);
    do_cycle(1'b1, A_CTRL, 32'h3);
    do_cycle(1'b1, A_MTIME, 32'd0);
    for (int i = 0; i < 8; i++) begin
      do_cycle(1'b0, 32'h0, 32'h0);
      check_read("mtime_count", A_MTIME);
    end
    chk("irq_after_match", {31'h0, timer_irq}, 32'h1);
    check_read("status_pending", A_STATUS);
    do_cycle(1'b1, A_STATUS, 32'h1);
    chk("irq_cleared", {31'h0, timer_irq}, 32'h0);
    check_read("status_cleared", A_STATUS);

    // Wrap-around
    do_cycle(1'b1, A_MTIME, 32'hFFFF_FFFE);
    check_read("mtime_loaded", A_MTIME);
    idle(2);
    check_read("mtime_wrap", A_MTIME);
    chk("mtime_wrap_const", bus.ReadData, 32'h0);

    // Unmapped write sets bus_err; W1C clears it
    do_cycle(1'b1, A_CTRL, 32'h0);
    do_cycle(1'b1, 32'h1000_0000, 32'h1234_5678);
    check_read("status_bus_err", A_STATUS);
    chk("status_bus_err_const", bus.ReadData, 32'h2);
    check_read("unmapped_read", 32'h1000_0000);
    do_cycle(1'b1, A_STATUS, 32'h2);
    check_read("bus_err_cleared", A_STATUS);

    // Compare hit and W1C clear in the same cycle: set wins
    do_cycle(1'b1, A_MTIME, 32'd5);
    do_cycle(1'b1, A_STATUS, 32'h1);
    check_read("set_wins", A_STATUS);
    chk("set_wins_const", bus.ReadData & 32'h1, 32'h1);
    do_cycle(1'b1, A_CMP, 32'd100);
    do_cycle(1'b1, A_STATUS, 32'h1);
    check_read("clear_after_move", A_STATUS);

    // Unused offsets and unused bits
    do_cycle(1'b1, MMIO_BASE + 32'h14, 32'hFFFF_FFFF);
    check_read("unused_off_0x14", MMIO_BASE + 32'h14);
    check_read("unused_off_no_err", A_STATUS);
    check_read("unused_off_0x1c", MMIO_BASE + 32'h1C);
    do_cycle(1'b1, A_CTRL, 32'hFFFF_FFFF);
    check_read("ctrl_masked", A_CTRL);
    do_cycle(1'b1, A_GPIO, 32'hFFFF_FF12);
    check_read("gpio_masked", A_GPIO);

    // Asynchronous reset in the middle of a GPIO write
    bus.MemWrite = 1'b1; bus.Mem_WrAddr = A_GPIO; bus.Mem_WrData = 32'h0000_00AA;
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_gpio", {24'h0, gpio_out}, 32'h0);
    chk("async_rst_irq", {31'h0, timer_irq}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    bus.MemWrite = 1'b0;
    model_reset();
    check_read("rst_mtimecmp_after", A_CMP);
    chk("rst_mtimecmp_const", bus.ReadData, 32'hFFFF_FFFF);
    do_cycle(1'b1, A_GPIO, 32'h33);
    check_read("first_edge_normal", A_GPIO);
    check_read("ram_survives_reset", 32'h0000_0010);

    // Randomized traffic
    for (int it = 0; it < 400; it++) begin
      op = int'($urandom_range(0, 7));
      d  = $urandom;
      case (op)
        0, 1: begin
          a = {22'h0, 8'($urandom_range(0, RAM_WORDS - 1)), 2'($urandom_range(0, 3))};
          do_cycle(1'b1, a, d);
          check_read("rnd_ram_wr", a);
        end
        2: begin
          if (m_keys.size() > 0) begin
            a = 32'(m_keys[$urandom_range(0, m_keys.size() - 1)]) * 4 + 32'($urandom_range(0, 3));
            check_read("rnd_ram_rd", a);
          end
          idle(1);
        end
        3, 4: begin
          a = MMIO_BASE + 32'($urandom_range(0, 7)) * 4;
          if (a == A_CMP) d = m_mtime + 32'($urandom_range(0, 6));
          if (a == A_MTIME && $urandom_range(0, 1) == 1) d = m_cmp - 32'($urandom_range(0, 3));
          do_cycle(1'b1, a, d);
          check_read("rnd_mmio_wr", a);
          check_read("rnd_status", A_STATUS);
        end
        5: begin
          a = {4'h1, 28'($urandom)};
          do_cycle(1'b1, a, d);
          check_read("rnd_unmapped", a);
          check_read("rnd_status_err", A_STATUS);
        end
        default: begin
          idle(1);
          check_read("rnd_mtime", A_MTIME);
          check_read("rnd_status_idle", A_STATUS);
        end
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter RAM_WORDS, default 256; number of 32-bit data RAM words, base address 0x0000_0000.
REQ-002 Parameter MMIO_BASE, default 0x0200_0000; base address of the 32-byte peripheral register window.
REQ-003 clk  input  1  single clock; all state updates occur on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 MemWrite  input  1  write strobe from the CPU, sampled at the rising edge of clk.
REQ-006 Mem_WrAddr  input  32  byte address for both read and write; bits [1:0] are ignored (word access only).
REQ-007 Mem_WrData  input  32  write data.
REQ-008 ReadData  output  32  read data for Mem_WrAddr, combinational.
REQ-009 gpio_out  output  8  GPIO output register.
REQ-010 timer_irq  output  1  timer interrupt request, level.

Function
REQ-011 Read latency SHALL be zero cycles: ReadData depends combinationally on Mem_WrAddr and the current state, as required by the single-cycle CPU.
REQ-012 Writes SHALL take effect at the rising edge of clk when MemWrite=1; a read of the same address in the next cycle returns the new value.
REQ-013 RAM hit: Mem_WrAddr < 4*RAM_WORDS; word index = Mem_WrAddr[log2(4*RAM_WORDS)-1:2].
REQ-014 MMIO hit: Mem_WrAddr[31:5] == MMIO_BASE[31:5]; register offset = Mem_WrAddr[4:2].
REQ-015 Register map (offset): 0x00 MTIME RW32; 0x04 MTIMECMP RW32; 0x08 CTRL RW[1:0] (bit0 count_en, bit1 irq_en); 0x0C STATUS W1C[1:0] (bit0 pending, bit1 bus_err); 0x10 GPIO RW[7:0]; all other offsets read 0 and ignore writes.
REQ-016 Unused register bits SHALL read as 0.
REQ-017 An address hitting neither region SHALL read 0x0000_0000; a write to it is discarded and sets STATUS.bus_err.
REQ-018 MTIME SHALL increment by 1 per cycle when count_en=1 and wrap from 0xFFFF_FFFF to 0x0000_0000.
REQ-019 A write to MTIME SHALL load Mem_WrData, overriding that cycle's increment.
REQ-020 STATUS.pending SHALL be set at the edge following any cycle in which MTIME == MTIMECMP, regardless of count_en.
REQ-021 A write to STATUS SHALL clear each bit written with 1; bits written with 0 are unchanged.
REQ-022 When a set condition and a W1C clear for the same bit occur in the same cycle, set SHALL win.
REQ-023 timer_irq SHALL equal STATUS.pending AND CTRL.irq_en, driven from registers with no combinational path from the inputs.
REQ-024 gpio_out SHALL equal GPIO[7:0].

Reset
REQ-025 Asserting reset SHALL immediately force the following values, independent of clk: MTIME=0, MTIMECMP=0xFFFF_FFFF, CTRL=0, STATUS=0, GPIO=0, timer_irq=0, gpio_out=0.
REQ-026 Reset SHALL override any write that is in flight.
REQ-027 RAM contents SHALL NOT be reset; they are undefined until written.
REQ-028 After reset deasserts, the first rising edge SHALL behave as a normal cycle.

Structure
REQ-029 Register offsets, CTRL/STATUS bit positions and MTIMECMP reset value SHALL live in a shared package/include, reusable by the CPU's test programs.
REQ-030 The timer (MTIME, MTIMECMP, CTRL, pending) SHALL be a sub-module named mmio_timer; RAM, address decode, GPIO and bus_err stay in mem_responder.

Verification
REQ-031 Write 0xDEADBEEF to 0x0000_0010, then read 0x0000_0010 and 0x0000_0013 -> ReadData=0xDEADBEEF for both.
REQ-032 Write 0x55 to 0x0200_0010 -> gpio_out=0x55 after the edge; a read of 0x0200_0010 returns 0x0000_0055.
REQ-033 Set MTIMECMP=5, CTRL=0x3, MTIME=0; count cycles -> pending and timer_irq rise after MTIME reaches 5; writing 0x1 to STATUS clears them.
REQ-034 Set MTIME=0xFFFF_FFFE with count_en=1 -> two cycles later MTIME reads 0x0000_0000.
REQ-035 Write to 0x1000_0000 -> STATUS reads 0x2 and ReadData for 0x1000_0000 is 0; writing 0x2 to STATUS clears bus_err.
REQ-036 Assert reset between two edges during a GPIO write -> gpio_out=0 immediately and MTIMECMP reads 0xFFFF_FFFF after release.
